// File: rtl/fp_add_pipe.sv
// Four-stage IEEE-754 style floating-point adder/subtractor: unpack, align, add, normalise/round/pack.
// One global enable drives the whole pipeline, so a stalled output freezes every stage together.
module fp_add_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_ovf,
  output logic         flag_unf,
  output logic         flag_inv,
  output logic         flag_inx
);

  localparam int EW   = MAN_W + 4;
  localparam int LZ_W = $clog2(EW + 1);
  localparam int XW   = EXP_W + LZ_W + 2;
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((2 ** EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = XW'(0);

  typedef struct packed {
    logic             sgn;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic             nan;
    logic             inf;
    logic             inf_sgn;
  } ctl_t;

  function automatic logic [LZ_W-1:0] lzc(input logic [EW-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(EW);
    for (int i = 0; i < EW; i++) begin
      if (v[i]) n = LZ_W'(EW - 1 - i);
    end
    return n;
  endfunction

  function automatic logic rne_inc(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  logic en;
  logic vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
  ctl_t ctl_p1_d, ctl_p1_q, ctl_p2_q, ctl_p3_q;
  logic [MAN_W:0]   man_big_p1_d, man_sml_p1_d, man_big_p1_q, man_sml_p1_q;
  logic [EXP_W-1:0] d_p1_d, d_p1_q;
  logic [EW-1:0]    big_p2_d, sml_p2_d, big_p2_q, sml_p2_q;
  logic [EW:0]      sum_p3_d, sum_p3_q;
  logic [LZ_W-1:0]  lz_p3_d, lz_p3_q;
  logic [W-1:0]     result_d, result_q;
  logic [3:0]       flags_d, flags_q;

  assign en        = ~(out_valid & ~out_ready);
  assign in_ready  = en;
  assign out_valid = vld_p4_q;
  assign result    = result_q;
  assign {flag_ovf, flag_unf, flag_inv, flag_inx} = flags_q;

  // S1: unpack, classify specials, order operands by magnitude
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_man, b_man;
  logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, b_sgn, a_big;

  always_comb begin
    a_exp  = a[W-2 -: EXP_W];
    b_exp  = b[W-2 -: EXP_W];
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_nan  = (a_exp == EXP_ONES) && (a[MAN_W-1:0] != '0);
    b_nan  = (b_exp == EXP_ONES) && (b[MAN_W-1:0] != '0);
    a_inf  = (a_exp == EXP_ONES) && (a[MAN_W-1:0] == '0);
    b_inf  = (b_exp == EXP_ONES) && (b[MAN_W-1:0] == '0);
    b_sgn  = b[W-1] ^ op_sub;
    // Denormals are flushed here by dropping their fraction along with the hidden bit.
    a_man  = a_zero ? '0 : {1'b1, a[MAN_W-1:0]};
    b_man  = b_zero ? '0 : {1'b1, b[MAN_W-1:0]};
    a_big  = {a_exp, a_man[MAN_W-1:0]} >= {b_exp, b_man[MAN_W-1:0]};
    ctl_p1_d.sgn     = a_big ? a[W-1] : b_sgn;
    ctl_p1_d.sub     = a[W-1] ^ b_sgn;
    ctl_p1_d.exp     = a_big ? a_exp : b_exp;
    ctl_p1_d.nan     = a_nan | b_nan | (a_inf & b_inf & (a[W-1] ^ b_sgn));
    ctl_p1_d.inf     = a_inf | b_inf;
    ctl_p1_d.inf_sgn = a_inf ? a[W-1] : b_sgn;
    man_big_p1_d = a_big ? a_man : b_man;
    man_sml_p1_d = a_big ? b_man : a_man;
    d_p1_d       = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
  end

  // S2: append G/R/S and align the smaller operand
  logic [31:0]     sh;
  logic [2*EW-1:0] wide;

  always_comb begin
    sh = 32'(d_p1_q);
    if (sh > 32'(EW)) sh = 32'(EW);
    wide     = {man_sml_p1_q, 3'b000, {EW{1'b0}}} >> sh;
    big_p2_d = {man_big_p1_q, 3'b000};
    sml_p2_d = {wide[2*EW-1:EW+1], wide[EW] | (|wide[EW-1:0])};
  end

  // S3: magnitude add or subtract; big >= small so the difference never goes negative
  always_comb begin
    if (ctl_p2_q.sub) sum_p3_d = {1'b0, big_p2_q} - {1'b0, sml_p2_q};
    else              sum_p3_d = {1'b0, big_p2_q} + {1'b0, sml_p2_q};
    lz_p3_d = lzc(sum_p3_d[EW-1:0]);
  end

  // S4: normalise, round to nearest even, pack with overflow/underflow and special overrides
  logic signed [XW-1:0] exp_n;
  logic [EW-1:0]        nrm;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     frac;
  logic                 inx;

  always_comb begin
    exp_n = $signed({{(XW-EXP_W){1'b0}}, ctl_p3_q.exp});
    if (sum_p3_q[EW]) begin
      nrm   = {sum_p3_q[EW:2], sum_p3_q[1] | sum_p3_q[0]};
      exp_n = exp_n + XW'(1);
    end else begin
      nrm   = sum_p3_q[EW-1:0] << lz_p3_q;
      exp_n = exp_n - $signed({{(XW-LZ_W){1'b0}}, lz_p3_q});
    end
    rnd = {1'b0, nrm[EW-1:3]} + {{(MAN_W+1){1'b0}}, rne_inc(nrm[3], nrm[2], nrm[1], nrm[0])};
    if (rnd[MAN_W+1]) begin
      exp_n = exp_n + XW'(1);
      frac  = rnd[MAN_W:1];
    end else begin
      frac  = rnd[MAN_W-1:0];
    end
    inx      = |nrm[2:0];
    result_d = {ctl_p3_q.sgn, exp_n[EXP_W-1:0], frac};
    flags_d  = {3'b000, inx};
    if (sum_p3_q == '0) begin
      result_d = {ctl_p3_q.sgn & ~ctl_p3_q.sub, {(W-1){1'b0}}};
      flags_d  = 4'b0000;
    end else if (exp_n >= EXP_MAX) begin
      result_d = {ctl_p3_q.sgn, EXP_ONES, {MAN_W{1'b0}}};
      flags_d  = 4'b1001;
    end else if (exp_n <= EXP_ZERO) begin
      result_d = {ctl_p3_q.sgn, {(W-1){1'b0}}};
      flags_d  = 4'b0101;
    end
    if (ctl_p3_q.nan) begin
      result_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d  = 4'b0010;
    end else if (ctl_p3_q.inf) begin
      result_d = {ctl_p3_q.inf_sgn, EXP_ONES, {MAN_W{1'b0}}};
      flags_d  = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (en) begin
      vld_p1_q <= in_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      vld_p4_q <= vld_p3_q;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      ctl_p1_q     <= ctl_p1_d;
      man_big_p1_q <= man_big_p1_d;
      man_sml_p1_q <= man_sml_p1_d;
      d_p1_q       <= d_p1_d;
      ctl_p2_q     <= ctl_p1_q;
      big_p2_q     <= big_p2_d;
      sml_p2_q     <= sml_p2_d;
      ctl_p3_q     <= ctl_p2_q;
      sum_p3_q     <= sum_p3_d;
      lz_p3_q      <= lz_p3_d;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe (binary16): directed vectors, backpressure stream, mid-stream reset.
module tb_fp_add_pipe;

  logic        clk, rst_n, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic        flag_ovf, flag_unf, flag_inv, flag_inx;

  typedef struct {
    logic [19:0] val;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sbq [$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [15:0] va [16];
  logic [15:0] vb [16];
  logic        vs [16];
  logic [19:0] ve [16];

  fp_add_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv), .flag_inx(flag_inx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_val("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check_val("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          check_val("result_flags", 32'({result, flag_ovf, flag_unf, flag_inv, flag_inx}), 32'(sbq[0].val));
          if (sbq[0].lat && out_ready) check_val("latency", 32'(cyc - sbq[0].acc), 32'd4);
          if (out_ready) sbq.delete(0);
        end
      end
    end
  end

  task automatic run_stream(input int first, input int n, input int st_lo, input int st_hi, input bit lat);
    int   idx = 0;
    int   c = 0;
    exp_t e;
    while ((idx < n || sbq.size() != 0) && c < 200) begin
      @(posedge clk);
      #1;
      out_ready = !(c >= st_lo && c <= st_hi);
      in_valid  = (idx < n);
      if (idx < n) begin
        a      = va[first + idx];
        b      = vb[first + idx];
        op_sub = vs[first + idx];
      end
      #1;
      if (in_valid && in_ready) begin
        e.val = ve[first + idx];
        e.acc = cyc;
        e.lat = lat;
        sbq.push_back(e);
        idx++;
      end
      c++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_val("drain", 32'(sbq.size()), 32'd0);
    check_val("all_sent", 32'(idx), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    va = '{16'h3C00, 16'h3C01, 16'h4000, 16'h3C01, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h7E01,
           16'h3C00, 16'h8000, 16'h7C00, 16'h0401, 16'h0001, 16'h7C00, 16'hFC00, 16'h3C00};
    vb = '{16'h4000, 16'h3C00, 16'h4000, 16'h1000, 16'h1000, 16'h7BFF, 16'hFC00, 16'h3C00,
           16'h4000, 16'h8000, 16'h3C00, 16'h0400, 16'h3C00, 16'h7C00, 16'hFC00, 16'h3C00};
    vs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    // {result, ovf, unf, inv, inx}
    ve = '{20'h4200_0, 20'h1400_0, 20'h0000_0, 20'h3C02_1, 20'h3C00_1, 20'h7C00_9, 20'h7E00_2, 20'h7E00_2,
           20'hBC00_0, 20'h8000_0, 20'h7C00_0, 20'h0000_5, 20'h3C00_0, 20'h7E00_2, 20'hFC00_0, 20'h4000_0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_flags", 32'({flag_ovf, flag_unf, flag_inv, flag_inx}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rdy_after_rst", 32'(in_ready), 32'd1);

    run_stream(0, 15, -1, -2, 1'b1);
    run_stream(0, 8, 5, 7, 1'b0);

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; a = va[i]; b = vb[i]; op_sub = vs[i]; out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("pre_rst_vld", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_result", 32'(result), 32'd0);
    check_val("midrst_flags", 32'({flag_ovf, flag_unf, flag_inv, flag_inx}), 32'd0);
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_rdy", 32'(in_ready), 32'd1);
    check_val("post_rst_vld", 32'(out_valid), 32'd0);

    run_stream(15, 1, -1, -2, 1'b1);
    repeat (6) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
